// File: rtl/wptr_full_level.sv
// Write-domain pointer manager for a dual-clock Gray-pointer FIFO.
// It holds the binary and Gray write pointers and drives the RAM write address.
// It registers full, almost-full and fill-level flags, computed against the
// read pointer after synchronisation into wclk. It also keeps a sticky
// overflow error flag.
// Ports:
//   wclk, wrst_n  write clock, async active-low reset
//   winc          producer write request
//   wq2_rptr      Gray read pointer synchronised into wclk
//   clr_ovf       clears the sticky overflow flag
//   waddr         RAM write address (low bits of binary write pointer)
//   wptr          registered Gray write pointer to the read-domain synchroniser
//   wfull         registered full flag
//   walmost_full  registered almost-full flag (level >= AFULL_THRESH)
//   wlevel        registered fill level as seen from the write side
//   wovf          sticky overflow: write attempted while full
module wptr_full_level #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                clr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;

  logic          accept;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_ptr;

  // Gray-to-binary of the synchronised read pointer, XOR prefix from the MSB.
  always_comb begin
    rbin_s = '0;
    rbin_s[PW-1] = wq2_rptr[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
  end

  // Full when the next Gray write pointer is exactly one lap ahead of the read pointer.
  assign full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // Next-state logic for pointers, flags and level.
  always_comb begin
    accept   = winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(accept);
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin_s;
    wfull_d  = (wptr_d == full_ptr);
    wafull_d = (wlevel_d >= PW'(AFULL_THRESH));
    // Set has priority over clear so a same-cycle overflow is never lost.
    wovf_d   = (winc & wfull_q) | (wovf_q & ~clr_ovf);
  end

  // State registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level (ADDRSIZE=4, AFULL_THRESH=12).
// The reference model tracks absolute write/read counts. The level is
// writes minus reads, full is level==16, and almost-full is level>=12.
module tb_wptr_full_level;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       clr_ovf;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int  errors = 0;
  int  checks = 0;
  bit  clk_en = 0;

  // Reference model state
  int  wr_abs, rd_abs, m_level;
  bit  m_full, m_afull, m_ovf;

  wptr_full_level #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .clr_ovf(clr_ovf), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  initial wclk = 1'b0;
  always begin
    #5;
    if (clk_en) wclk = ~wclk;
  end

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    wr_abs = 0; rd_abs = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit inc, input bit clr, input int rd);
    bit acc;
    winc = inc; clr_ovf = clr; rd_abs = rd; wq2_rptr = gray(rd);
    acc   = inc && !m_full;
    m_ovf = (inc && m_full) || (m_ovf && !clr);
    if (acc) wr_abs++;
    m_level = wr_abs - rd_abs;
    m_full  = (m_level == 16);
    m_afull = (m_level >= 12);
    @(posedge wclk); #1;
  endtask

  task automatic test_reset();
    winc = 0; clr_ovf = 0; wq2_rptr = '0; wrst_n = 1'b1;
    #3 wrst_n = 1'b0;
    #1;
    checks++;
    if ({waddr, wptr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
      errors++;
      $display("FAIL reset_no_clock act=%b exp=0", {waddr, wptr, wfull, walmost_full, wlevel, wovf});
    end
    model_reset();
    #2 wrst_n = 1'b1;
    clk_en = 1;
    @(posedge wclk); #1;
    checks++;
    if (wfull !== 1'b0 || wlevel !== 5'd0) begin
      errors++;
      $display("FAIL reset_after_clock wfull=%b wlevel=%0d exp 0/0", wfull, wlevel);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 0);
      checks++;
      if (wlevel !== 5'(i) || walmost_full !== (i >= 12) || wfull !== (i == 16) ||
          waddr !== 4'(i % 16)) begin
        errors++;
        $display("FAIL fill_%0d lvl=%0d af=%b f=%b addr=%0d exp lvl=%0d af=%b f=%b addr=%0d",
                 i, wlevel, walmost_full, wfull, waddr, i, (i >= 12), (i == 16), i % 16);
      end
    end
    checks++;
    if (wptr !== 5'b11000) begin
      errors++;
      $display("FAIL fill_wptr act=%b exp=11000", wptr);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0);
    checks++;
    if (wptr !== 5'b11000 || wlevel !== 5'd16 || wovf !== 1'b1 || wfull !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set wptr=%b lvl=%0d ovf=%b full=%b exp 11000/16/1/1", wptr, wlevel, wovf, wfull);
    end
    cycle(0, 1, 0);
    checks++;
    if (wovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear act=%b exp=0", wovf);
    end
    cycle(1, 1, 0);
    checks++;
    if (wovf !== 1'b1 || wptr !== 5'b11000) begin
      errors++;
      $display("FAIL ovf_set_wins ovf=%b wptr=%b exp 1/11000", wovf, wptr);
    end
    cycle(0, 1, 0);
  endtask

  task automatic test_unfull();
    cycle(0, 0, 4);
    checks++;
    if (wfull !== 1'b0 || wlevel !== 5'd12 || walmost_full !== 1'b1) begin
      errors++;
      $display("FAIL unfull f=%b lvl=%0d af=%b exp 0/12/1", wfull, wlevel, walmost_full);
    end
    cycle(1, 0, 4);
    checks++;
    if (wlevel !== 5'd13 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL unfull_write lvl=%0d f=%b exp 13/0", wlevel, wfull);
    end
  endtask

  task automatic test_simultaneous();
    // Write and one-step read advance together: level unchanged.
    cycle(1, 0, rd_abs + 1);
    checks++;
    if (wlevel !== 5'd13) begin
      errors++;
      $display("FAIL simul_level act=%0d exp=13", wlevel);
    end
  endtask

  task automatic test_wrap();
    while (wr_abs < 30) cycle(1, 0, wr_abs - 4);
    cycle(0, 0, 28);
    checks++;
    if (wlevel !== 5'd2 || waddr !== 4'd14) begin
      errors++;
      $display("FAIL wrap_setup lvl=%0d addr=%0d exp 2/14", wlevel, waddr);
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, 28);
    checks++;
    if (wptr !== 5'b00011 || wlevel !== 5'd6 || wfull !== 1'b0 || waddr !== 4'd2) begin
      errors++;
      $display("FAIL wrap wptr=%b lvl=%0d f=%b addr=%0d exp 00011/6/0/2", wptr, wlevel, wfull, waddr);
    end
  endtask

  task automatic test_random();
    int avail, rd_new;
    bit inc, clr;
    for (int i = 0; i < 400; i++) begin
      inc = ((i % 100) < 60) ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
      clr = ($urandom % 8 == 0);
      avail = wr_abs - rd_abs;
      rd_new = rd_abs + int'($urandom_range(0, (avail < 2) ? avail : 2));
      cycle(inc, clr, rd_new);
      checks++;
      if (wlevel !== 5'(m_level) || wfull !== m_full || walmost_full !== m_afull ||
          wovf !== m_ovf || waddr !== 4'(wr_abs % 16) || wptr !== gray(wr_abs)) begin
        errors++;
        $display("FAIL random_%0d lvl=%0d/%0d f=%b/%b af=%b/%b ovf=%b/%b addr=%0d/%0d wptr=%b/%b",
                 i, wlevel, m_level, wfull, m_full, walmost_full, m_afull, wovf, m_ovf,
                 waddr, wr_abs % 16, wptr, gray(wr_abs));
      end
    end
  endtask

  task automatic test_reset_midburst();
    cycle(0, 1, wr_abs);
    for (int i = 0; i < 9; i++) cycle(1, 0, rd_abs);
    checks++;
    if (wlevel !== 5'd9) begin
      errors++;
      $display("FAIL midburst_level act=%0d exp=9", wlevel);
    end
    winc = 1;
    #2 wrst_n = 1'b0;
    #1;
    checks++;
    if ({waddr, wptr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
      errors++;
      $display("FAIL midburst_reset act=%b exp=0", {waddr, wptr, wfull, walmost_full, wlevel, wovf});
    end
    model_reset();
    winc = 0; wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    checks++;
    if (waddr !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_addr act=%0d exp=0", waddr);
    end
    cycle(1, 0, 0);
    checks++;
    if (wlevel !== 5'd1 || waddr !== 4'd1 || wptr !== 5'b00001) begin
      errors++;
      $display("FAIL post_reset_write lvl=%0d addr=%0d wptr=%b exp 1/1/00001", wlevel, waddr, wptr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_unfull();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
